// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: read-side packet engine for the async FIFO (read clock domain).
// Pops words from the FIFO, strips the length header of each packet and streams
// the payload downstream (valid/ready, sop/eop) through a 2-entry output buffer.
// Optional feature: define FIFO_RD_STATS_EN to add the stall_count output.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  rd_req,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  zero_len_err
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_inflight;      // a popped word appears on fifo_rdata this cycle
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_rem_issue;
    logic [LEN_WIDTH-1:0]  r_rem_recv;

    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_sop;
    logic [1:0]            r_buf_eop;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_occ;

    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_deq;
    logic                  w_hdr_ret;
    logic                  w_pl_ret;
    logic [1:0]            w_occ_after;
    logic                  w_credit;
    logic                  w_pop_ok;

    assign w_len       = fifo_rdata[LEN_WIDTH-1:0];
    assign w_deq       = m_valid & m_ready;
    assign w_hdr_ret   = (r_state == S_HDR) && r_inflight;
    assign w_pl_ret    = (r_state == S_PAYLOAD) && r_inflight;
    // The word leaving this cycle frees its slot, which is what sustains 1 word/cycle.
    assign w_occ_after = r_occ - {1'b0, w_deq};
    // A returning header never occupies the buffer, so only payload in flight takes credit.
    assign w_credit    = (w_occ_after + {1'b0, w_pl_ret}) < 2'd2;
    assign w_pop_ok    = !rrst && !fifo_empty && w_credit;

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_buf_data[r_rd_ptr];
    assign m_sop   = r_buf_sop[r_rd_ptr];
    assign m_eop   = r_buf_eop[r_rd_ptr];
    assign busy    = (r_state != S_IDLE) || (r_occ != 2'd0);

    // State register.
    always_ff @(posedge r_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rrst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state: enable is only consulted at packet boundaries.
    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next_state = S_HDR;
            S_HDR: begin
                if (r_inflight) begin
                    if (w_len == '0) w_next_state = enable ? S_HDR : S_IDLE;
                    else             w_next_state = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (r_inflight && (r_rem_recv == LEN_WIDTH'(1)))
                    w_next_state = enable ? S_HDR : S_IDLE;
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Pop request: one header pop, then payload pops; the first payload pop is
    // issued in the same cycle the header returns to save a bubble.
    always_comb begin
        rd_req = 1'b0;
        case (r_state)
            S_HDR:     rd_req = w_pop_ok && (!r_inflight || (w_len != '0));
            S_PAYLOAD: rd_req = w_pop_ok && (r_rem_issue != '0);
            default:   rd_req = 1'b0;
        endcase
    end

    // Packet bookkeeping: in-flight flag, remaining counts, packet counter, error flag.
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            r_inflight   <= 1'b0;
            r_len        <= '0;
            r_rem_issue  <= '0;
            r_rem_recv   <= '0;
            pkt_count    <= '0;
            zero_len_err <= 1'b0;
        end else begin
            r_inflight <= rd_req;
            if (w_hdr_ret) begin
                if (w_len == '0) begin
                    zero_len_err <= 1'b1;
                end else begin
                    r_len       <= w_len;
                    r_rem_recv  <= w_len;
                    r_rem_issue <= w_len - LEN_WIDTH'(rd_req);
                end
            end
            if (w_pl_ret)
                r_rem_recv <= r_rem_recv - LEN_WIDTH'(1);
            if ((r_state == S_PAYLOAD) && rd_req)
                r_rem_issue <= r_rem_issue - LEN_WIDTH'(1);
            if (w_deq && m_eop)
                pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

    // Two-entry output buffer, FIFO ordered; returning payload words always have a slot.
    always_ff @(posedge r_clk) begin
        if (rrst) begin
            // NOTE: buffer storage is reset because m_data reads it directly and must be 0 after reset.
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_sop     <= '0;
            r_buf_eop     <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (w_pl_ret) begin
                r_buf_data[r_wr_ptr] <= fifo_rdata;
                r_buf_sop[r_wr_ptr]  <= (r_rem_recv == r_len);
                r_buf_eop[r_wr_ptr]  <= (r_rem_recv == LEN_WIDTH'(1));
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_deq)
                r_rd_ptr <= ~r_rd_ptr;
            r_occ <= r_occ + {1'b0, w_pl_ret} - {1'b0, w_deq};
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic w_stall;
    assign w_stall = (m_valid && !m_ready) ||
                     ((r_state == S_PAYLOAD) && (r_rem_issue != '0) && w_credit && fifo_empty);

    // Stall counter: downstream backpressure or payload starved by an empty FIFO.
    always_ff @(posedge r_clk) begin
        if (rrst)         stall_count <= '0;
        else if (w_stall) stall_count <= stall_count + CNT_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed testbench for fifo_pkt_reader with a behavioural FIFO read port
// and a downstream monitor recording every handshake.
module tb_fifo_pkt_reader;
    localparam int DW = 32;
    localparam int LW = 9;
    localparam int CW = 16;

    logic          r_clk = 1'b0;
    logic          rrst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          m_ready = 1'b0;
    logic          rd_req, m_valid, m_sop, m_eop, busy, zero_len_err;
    logic [DW-1:0] m_data;
    logic [CW-1:0] pkt_count;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]   fq [$];     // words waiting in the FIFO
    logic [DW+1:0]   rx_q [$];   // delivered beats {sop, eop, data}
    int              rx_t [$];   // cycle of each delivered beat
    int              pop_t [$];  // cycle of each accepted pop
    int              cyc = 0;
    int              rd_viol = 0;
    int              stab_viol = 0;
    logic            stall_pend = 1'b0;
    logic [DW+1:0]   stall_word = '0;

    fifo_pkt_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .r_clk        (r_clk),
        .rrst         (rrst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .rd_req       (rd_req),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sop        (m_sop),
        .m_eop        (m_eop),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .zero_len_err (zero_len_err)
    );

    always #5 r_clk = ~r_clk;

    // FIFO read-port model and downstream monitor.
    always @(posedge r_clk) begin : model
        logic acc;
        cyc++;
        acc = rd_req && !fifo_empty;
        if (rd_req && fifo_empty) rd_viol++;
        if (m_valid && m_ready && !rrst) begin
            rx_q.push_back({m_sop, m_eop, m_data});
            rx_t.push_back(cyc);
        end
        if (stall_pend && m_valid && !rrst && ({m_sop, m_eop, m_data} !== stall_word)) stab_viol++;
        stall_pend = m_valid && !m_ready && !rrst;
        stall_word = {m_sop, m_eop, m_data};
        if (acc) pop_t.push_back(cyc);
        #1;
        if (acc && fq.size() > 0) fifo_rdata = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    task automatic reset_dut();
        @(negedge r_clk);
        rrst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        fq.delete();
        cycles(2);
        rrst = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge r_clk);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        tests++;
        if ({rd_req, m_valid, m_sop, m_eop, busy, zero_len_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000", {rd_req, m_valid, m_sop, m_eop, busy, zero_len_err});
        end
        tests++;
        if (m_data !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", m_data);
        end
        tests++;
        if (pkt_count !== '0) begin
            fails++;
            $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count);
        end
    endtask

    task automatic test_basic();
        int rb;
        int pb;
        bit ok;
        logic [DW+1:0] exp_b [3];
        exp_b = '{{2'b10, 32'hA1}, {2'b00, 32'hA2}, {2'b01, 32'hA3}};
        reset_dut();
        rb = rx_q.size();
        pb = pop_t.size();
        fq.push_back(32'hABCD_E003);   // length 3, upper header bits ignored
        fq.push_back(32'hA1);
        fq.push_back(32'hA2);
        fq.push_back(32'hA3);
        enable = 1'b1;
        m_ready = 1'b1;
        @(negedge r_clk);
        enable = 1'b0;
        wait_rx(rb + 3, 50, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_timeout: got %0d beats expected 3", rx_q.size() - rb);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rx_q[rb+i] !== exp_b[i]) begin
                fails++;
                $display("FAIL basic_beat%0d: got %h expected %h", i, rx_q[rb+i], exp_b[i]);
            end
        end
        tests++;
        if ((rx_t[rb+1] - rx_t[rb] != 1) || (rx_t[rb+2] - rx_t[rb+1] != 1)) begin
            fails++;
            $display("FAIL basic_back_to_back: got gaps %0d,%0d expected 1,1",
                     rx_t[rb+1] - rx_t[rb], rx_t[rb+2] - rx_t[rb+1]);
        end
        tests++;
        if (rx_t[rb] - pop_t[pb] != 3) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 3", rx_t[rb] - pop_t[pb]);
        end
        cycles(3);
        tests++;
        if (pkt_count !== 16'd1) begin
            fails++;
            $display("FAIL basic_pkt_count: got %0d expected 1", pkt_count);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_word();
        int rb;
        bit ok;
        logic [DW+1:0] exp_b [3];
        exp_b = '{{2'b11, 32'hB1}, {2'b10, 32'hC1}, {2'b01, 32'hC2}};
        reset_dut();
        rb = rx_q.size();
        fq.push_back(32'd1);
        fq.push_back(32'hB1);
        fq.push_back(32'd2);
        fq.push_back(32'hC1);
        fq.push_back(32'hC2);
        enable = 1'b1;
        m_ready = 1'b1;
        wait_rx(rb + 3, 60, ok);
        enable = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_timeout: got %0d beats expected 3", rx_q.size() - rb);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rx_q[rb+i] !== exp_b[i]) begin
                fails++;
                $display("FAIL single_beat%0d: got %h expected %h", i, rx_q[rb+i], exp_b[i]);
            end
        end
        tests++;
        if (rx_t[rb+1] - rx_t[rb] != 3) begin
            fails++;
            $display("FAIL single_hdr_gap: got %0d expected 3", rx_t[rb+1] - rx_t[rb]);
        end
        cycles(3);
        tests++;
        if (pkt_count !== 16'd2) begin
            fails++;
            $display("FAIL single_pkt_count: got %0d expected 2", pkt_count);
        end
    endtask

    task automatic test_backpressure();
        int rb;
        int pb;
        int sv;
        int rv;
        int held;
        int max_held = 0;
        int credit_seen = 0;
        bit done = 1'b0;
        reset_dut();
        rb = rx_q.size();
        pb = pop_t.size();
        sv = stab_viol;
        rv = rd_viol;
        fq.push_back(32'd8);
        for (int i = 0; i < 8; i++) fq.push_back(32'h100 + i);
        enable = 1'b1;
        @(negedge r_clk);
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            m_ready = ((i % 4) == 0) || ((i % 4) == 3);
            #1;
            held = (pop_t.size() - pb > 0) ? (pop_t.size() - pb - 1) - (rx_q.size() - rb) : 0;
            if (held > max_held) max_held = held;
            if (busy && !fifo_empty && !rd_req && m_valid && !m_ready) credit_seen++;
            if (rx_q.size() >= rb + 8) begin
                done = 1'b1;
                break;
            end
            @(negedge r_clk);
        end
        m_ready = 1'b1;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL bp_timeout: got %0d beats expected 8", rx_q.size() - rb);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            logic [DW+1:0] e;
            e = {(i == 0), (i == 7), 32'h100 + i};
            tests++;
            if (rx_q[rb+i] !== e) begin
                fails++;
                $display("FAIL bp_beat%0d: got %h expected %h", i, rx_q[rb+i], e);
            end
        end
        tests++;
        if (stab_viol != sv) begin
            fails++;
            $display("FAIL bp_stable: got %0d unstable stalls expected 0", stab_viol - sv);
        end
        tests++;
        if (max_held > 2) begin
            fails++;
            $display("FAIL bp_held: got max %0d words held expected <= 2", max_held);
        end
        tests++;
        if (credit_seen == 0) begin
            fails++;
            $display("FAIL bp_credit: got 0 credit-blocked cycles expected > 0");
        end
        tests++;
        if (rd_viol != rv) begin
            fails++;
            $display("FAIL bp_rd_empty: got %0d pops on empty expected 0", rd_viol - rv);
        end
        cycles(2);
        tests++;
        if (pkt_count !== 16'd1) begin
            fails++;
            $display("FAIL bp_pkt_count: got %0d expected 1", pkt_count);
        end
    endtask

    task automatic test_empty_mid();
        int rb;
        int bad = 0;
        bit ok;
        reset_dut();
        rb = rx_q.size();
        fq.push_back(32'd4);
        fq.push_back(32'hE1);
        fq.push_back(32'hE2);
        enable = 1'b1;
        m_ready = 1'b1;
        @(negedge r_clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            if (fifo_empty && rd_req) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL empty_rd_req: got %0d requests while empty expected 0", bad);
        end
        tests++;
        if ((rx_q.size() - rb != 2) || (busy !== 1'b1)) begin
            fails++;
            $display("FAIL empty_partial: got %0d beats busy=%b expected 2 beats busy=1", rx_q.size() - rb, busy);
        end
        fq.push_back(32'hE3);
        fq.push_back(32'hE4);
        wait_rx(rb + 4, 30, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL empty_timeout: got %0d beats expected 4", rx_q.size() - rb);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            logic [DW+1:0] e;
            e = {(i == 0), (i == 3), 32'hE1 + i};
            tests++;
            if (rx_q[rb+i] !== e) begin
                fails++;
                $display("FAIL empty_beat%0d: got %h expected %h", i, rx_q[rb+i], e);
            end
        end
    endtask

    task automatic test_zero_len_enable();
        int rb;
        int pb;
        bit ok;
        bit seen = 1'b0;
        reset_dut();
        rb = rx_q.size();
        pb = pop_t.size();
        fq.push_back(32'h0000_7E00);   // length field 0, upper bits set
        fq.push_back(32'd2);
        fq.push_back(32'hD1);
        fq.push_back(32'hD2);
        fq.push_back(32'd1);
        fq.push_back(32'hF00D);
        enable = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge r_clk);
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL zl_timeout: got no valid beat expected D1");
            return;
        end
        wait_rx(rb + 2, 20, ok);
        cycles(10);
        tests++;
        if (!ok || (rx_q.size() - rb != 2)) begin
            fails++;
            $display("FAIL zl_beats: got %0d beats expected 2", rx_q.size() - rb);
            return;
        end
        tests++;
        if ((rx_q[rb] !== {2'b10, 32'hD1}) || (rx_q[rb+1] !== {2'b01, 32'hD2})) begin
            fails++;
            $display("FAIL zl_data: got %h,%h expected %h,%h", rx_q[rb], rx_q[rb+1],
                     {2'b10, 32'hD1}, {2'b01, 32'hD2});
        end
        tests++;
        if (zero_len_err !== 1'b1) begin
            fails++;
            $display("FAIL zl_err_sticky: got %b expected 1", zero_len_err);
        end
        tests++;
        if ((busy !== 1'b0) || (fq.size() != 2) || (pop_t.size() - pb != 4)) begin
            fails++;
            $display("FAIL zl_idle_stop: got busy=%b fifo_left=%0d pops=%0d expected 0,2,4",
                     busy, fq.size(), pop_t.size() - pb);
        end
        tests++;
        if (pkt_count !== 16'd1) begin
            fails++;
            $display("FAIL zl_pkt_count: got %0d expected 1", pkt_count);
        end
    endtask

    task automatic test_reset_mid();
        int rb;
        int pb;
        bit ok;
        bit seen = 1'b0;
        reset_dut();
        rb = rx_q.size();
        fq.push_back(32'd0);
        fq.push_back(32'd1);
        fq.push_back(32'h61);
        fq.push_back(32'd5);
        for (int i = 0; i < 5; i++) fq.push_back(32'hF1 + i);
        enable = 1'b1;
        m_ready = 1'b1;
        wait_rx(rb + 1, 40, ok);
        m_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge r_clk);
        end
        tests++;
        if (!ok || !seen || (pkt_count !== 16'd1) || (zero_len_err !== 1'b1)) begin
            fails++;
            $display("FAIL rst_setup: got ok=%b valid=%b pkt_count=%0d err=%b expected 1,1,1,1",
                     ok, seen, pkt_count, zero_len_err);
            return;
        end
        rrst = 1'b1;
        enable = 1'b0;
        @(negedge r_clk);
        rrst = 1'b0;
        tests++;
        if ({rd_req, m_valid, m_sop, m_eop, busy, zero_len_err} !== 6'b0) begin
            fails++;
            $display("FAIL rst_mid_flags: got %b expected 000000", {rd_req, m_valid, m_sop, m_eop, busy, zero_len_err});
        end
        tests++;
        if ((m_data !== '0) || (pkt_count !== '0)) begin
            fails++;
            $display("FAIL rst_mid_regs: got data=%h pkt_count=%0d expected 0,0", m_data, pkt_count);
        end
        pb = pop_t.size();
        cycles(5);
        tests++;
        if ((pop_t.size() != pb) || (busy !== 1'b0)) begin
            fails++;
            $display("FAIL rst_mid_idle: got pops=%0d busy=%b expected 0,0", pop_t.size() - pb, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_word();
        test_backpressure();
        test_empty_mid();
        test_zero_len_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
